// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: load-use stall detection, register-file read with
// same-cycle write-back bypass, ID/EX pipeline register and EX-stage
// operand forwarding from EX/MEM and MEM/WB.
module id_ex_operand_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      id_Rs1,
  input  logic [4:0]      id_Rs2,
  input  logic [4:0]      id_Rd,
  input  logic            id_RegWrite,
  input  logic            id_MemRead,
  output logic [4:0]      Rs1,
  output logic [4:0]      Rs2,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  input  logic            exmem_RegWrite,
  input  logic [4:0]      exmem_Rd,
  input  logic [XLEN-1:0] exmem_ALUResult,
  input  logic            memwb_RegWrite,
  input  logic [4:0]      memwb_Rd,
  input  logic [XLEN-1:0] memwb_WriteData,
  input  logic            flush,
  output logic            ex_valid,
  output logic            ex_RegWrite,
  output logic            ex_MemRead,
  output logic [4:0]      ex_Rd,
  output logic [XLEN-1:0] ex_Op1,
  output logic [XLEN-1:0] ex_Op2,
  output logic [1:0]      ForwardA,
  output logic [1:0]      ForwardB
);

  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memread;
    logic [XLEN-1:0] raw1;
    logic [XLEN-1:0] raw2;
  } idex_t;

  idex_t idex_q, idex_d;
  logic  hazard;

  // x0 reads as zero; a write-back landing this cycle beats the stale RF read.
  function automatic logic [XLEN-1:0] capture(input logic [4:0] rs,
                                              input logic [XLEN-1:0] rf);
    if (rs == 5'd0)                           return '0;
    else if (memwb_RegWrite && memwb_Rd == rs) return memwb_WriteData;
    else                                       return rf;
  endfunction

  // EX/MEM wins over MEM/WB; never forward into x0; nothing when EX is a bubble.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (!idex_q.valid)                                            return 2'b00;
    else if (exmem_RegWrite && exmem_Rd != 5'd0 && exmem_Rd == rs) return 2'b10;
    else if (memwb_RegWrite && memwb_Rd != 5'd0 && memwb_Rd == rs) return 2'b01;
    else                                                           return 2'b00;
  endfunction

  assign Rs1 = id_Rs1;
  assign Rs2 = id_Rs2;

  // Load in EX whose result a decoding instruction needs: hold IF/ID one cycle.
  assign hazard   = idex_q.valid && idex_q.memread && idex_q.rd != 5'd0 &&
                    (idex_q.rd == id_Rs1 || idex_q.rd == id_Rs2);
  assign in_ready = reset || !hazard;

  // Next ID/EX contents: accepted instruction, otherwise an all-zero bubble.
  always_comb begin
    idex_d = '0;
    if (!flush && in_valid && !hazard) begin
      idex_d.valid    = 1'b1;
      idex_d.rs1      = id_Rs1;
      idex_d.rs2      = id_Rs2;
      idex_d.rd       = id_Rd;
      idex_d.regwrite = id_RegWrite;
      idex_d.memread  = id_MemRead;
      idex_d.raw1     = capture(id_Rs1, ReadData1);
      idex_d.raw2     = capture(id_Rs2, ReadData2);
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  // EX-stage forwarding select and operand muxes.
  always_comb begin
    ForwardA = fwd_sel(idex_q.rs1);
    ForwardB = fwd_sel(idex_q.rs2);
    unique case (ForwardA)
      2'b10:   ex_Op1 = exmem_ALUResult;
      2'b01:   ex_Op1 = memwb_WriteData;
      default: ex_Op1 = idex_q.raw1;
    endcase
    unique case (ForwardB)
      2'b10:   ex_Op2 = exmem_ALUResult;
      2'b01:   ex_Op2 = memwb_WriteData;
      default: ex_Op2 = idex_q.raw2;
    endcase
  end

  assign ex_valid    = idex_q.valid;
  assign ex_RegWrite = idex_q.regwrite;
  assign ex_MemRead  = idex_q.memread;
  assign ex_Rd       = idex_q.rd;

endmodule
